// File: rtl/mem_stage.sv
// Memory stage: drives a single-outstanding data-cache request, formats big-endian
// load/store lanes and registers the WB-side results plus the MEM->EXE bypass.
module mem_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  input  logic        stall_IC,
  output logic        stall_MEM,
  output logic        dreq_valid,
  input  logic        dreq_ready,
  output logic        dreq_write,
  output logic [31:0] dreq_addr,
  output logic [31:0] dreq_wdata,
  output logic [3:0]  dreq_be,
  input  logic        dresp_valid,
  input  logic [31:0] dresp_rdata,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic        Misalign_OUT,
  output logic [4:0]  BypassReg1_MEMEXE,
  output logic [31:0] BypassData1_MEMEXE,
  output logic        BypassValid1_MEMEXE
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic [31:0] load_fmt(input logic [5:0] op, input logic [1:0] k,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (k)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = k[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   load_fmt = {{24{b[7]}}, b};
      OP_LBU:  load_fmt = {24'h000000, b};
      OP_LH:   load_fmt = {{16{h[15]}}, h};
      OP_LHU:  load_fmt = {16'h0000, h};
      default: load_fmt = rd;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [5:0] op, input logic [31:0] rt);
    case (op)
      OP_SB:   store_wdata = {4{rt[7:0]}};
      OP_SH:   store_wdata = {2{rt[15:0]}};
      default: store_wdata = rt;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] k);
    case (op)
      OP_SB:   store_be = 4'b1000 >> k;
      OP_SH:   store_be = k[1] ? 4'b0011 : 4'b1100;
      default: store_be = 4'b1111;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d, pc_q, pc_d, wdata_q, wdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regwr_q, regwr_d, misal_q, misal_d;

  logic        is_load, is_store, misal_raw;
  logic        memop, misalign, mem_go;
  logic [1:0]  lane;
  logic [31:0] load_data, mem_rdata;

  assign lane = ALU_result1_IN[1:0];

  // Opcode decode and alignment check
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    misal_raw = 1'b0;
    case (ALU_Control1_IN)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; misal_raw = lane[0]; end
      OP_LW:         begin is_load = 1'b1; misal_raw = |lane; end
      OP_SB:         is_store = 1'b1;
      OP_SH:         begin is_store = 1'b1; misal_raw = lane[0]; end
      OP_SW:         begin is_store = 1'b1; misal_raw = |lane; end
      default:       begin is_load = 1'b0; is_store = 1'b0; misal_raw = 1'b0; end
    endcase
  end

  assign memop    = (MemRead1_IN | MemWrite1_IN) & (is_load | is_store);
  assign misalign = memop & misal_raw;
  assign mem_go   = memop & ~misalign;

  // Gating with RESET keeps the handshake quiet while reset is held even if EXE shows a memop.
  assign dreq_valid = RESET & (state_q == ST_IDLE) & mem_go;
  assign stall_MEM  = RESET & mem_go &
                      ~(((state_q == ST_WAIT) & dresp_valid & ~stall_IC) |
                        ((state_q == ST_HOLD) & ~stall_IC));
  assign dreq_write = MemWrite1_IN;
  assign dreq_addr  = {ALU_result1_IN[31:2], 2'b00};
  assign dreq_wdata = is_store ? store_wdata(ALU_Control1_IN, MemWriteData1_IN) : 32'h00000000;
  assign dreq_be    = is_store ? store_be(ALU_Control1_IN, lane) : 4'b1111;

  assign load_data = load_fmt(ALU_Control1_IN, lane, dresp_rdata);
  assign mem_rdata = (state_q == ST_HOLD) ? buf_q : load_data;

  // Next-state for the access FSM, the hold buffer and the WB registers
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    wdata_d = wdata_q;
    wreg_d  = wreg_q;
    regwr_d = regwr_q;
    misal_d = misal_q;
    case (state_q)
      ST_IDLE: begin
        if (dreq_valid && dreq_ready) state_d = ST_WAIT;
        else                          state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (dresp_valid) begin
          if (stall_IC) begin
            state_d = ST_HOLD;
            buf_d   = load_data;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (!stall_IC) state_d = ST_IDLE;
        else           state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase

    if (stall_IC) begin
      instr_d = instr_q;
    end else if (stall_MEM) begin
      instr_d = 32'h00000000;
      regwr_d = 1'b0;
      misal_d = 1'b0;
    end else begin
      instr_d = Instr1_IN;
      pc_d    = Instr1_PC_IN;
      wreg_d  = WriteRegister1_IN;
      wdata_d = (mem_go && is_load) ? mem_rdata : ALU_result1_IN;
      regwr_d = RegWrite1_IN & ~(memop & is_store) & ~misalign;
      misal_d = misalign;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      buf_q   <= 32'h00000000;
      instr_q <= 32'h00000000;
      pc_q    <= 32'h00000000;
      wdata_q <= 32'h00000000;
      wreg_q  <= 5'd0;
      regwr_q <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      regwr_q <= regwr_d;
      misal_q <= misal_d;
    end
  end

  assign Instr1_OUT          = instr_q;
  assign Instr1_PC_OUT       = pc_q;
  assign WriteData1_OUT      = wdata_q;
  assign WriteRegister1_OUT  = wreg_q;
  assign RegWrite1_OUT       = regwr_q;
  assign Misalign_OUT        = misal_q;
  assign BypassReg1_MEMEXE   = wreg_q;
  assign BypassData1_MEMEXE  = wdata_q;
  assign BypassValid1_MEMEXE = regwr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, stalled handshake,
// misalignment and reset abandonment, each against hand-computed values.
module tb_mem_stage;

  logic        CLK, RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN, stall_IC;
  logic [5:0]  ALU_Control1_IN;
  logic        stall_MEM, dreq_valid, dreq_ready, dreq_write, dresp_valid;
  logic [31:0] dreq_addr, dreq_wdata, dresp_rdata;
  logic [3:0]  dreq_be;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, BypassData1_MEMEXE;
  logic [4:0]  WriteRegister1_OUT, BypassReg1_MEMEXE;
  logic        RegWrite1_OUT, Misalign_OUT, BypassValid1_MEMEXE;

  int n_chk = 0;
  int n_bad = 0;

  mem_stage dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN), .ALU_result1_IN(ALU_result1_IN),
    .WriteRegister1_IN(WriteRegister1_IN), .MemWriteData1_IN(MemWriteData1_IN),
    .RegWrite1_IN(RegWrite1_IN), .ALU_Control1_IN(ALU_Control1_IN),
    .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN), .stall_IC(stall_IC),
    .stall_MEM(stall_MEM), .dreq_valid(dreq_valid), .dreq_ready(dreq_ready),
    .dreq_write(dreq_write), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .dreq_be(dreq_be), .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT), .WriteData1_OUT(WriteData1_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
    .Misalign_OUT(Misalign_OUT), .BypassReg1_MEMEXE(BypassReg1_MEMEXE),
    .BypassData1_MEMEXE(BypassData1_MEMEXE), .BypassValid1_MEMEXE(BypassValid1_MEMEXE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_nop();
    Instr1_IN = 32'h00000000; Instr1_PC_IN = 32'h00000000; ALU_result1_IN = 32'h00000000;
    WriteRegister1_IN = 5'd0; MemWriteData1_IN = 32'h00000000; RegWrite1_IN = 1'b0;
    ALU_Control1_IN = 6'h00; MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0;
    dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_rdata = 32'h00000000;
  endtask

  task automatic set_mem(input logic [5:0] op, input logic [31:0] addr, input logic rd,
                         input logic [4:0] wr, input logic [31:0] instr);
    ALU_Control1_IN = op; ALU_result1_IN = addr; MemRead1_IN = rd; MemWrite1_IN = ~rd;
    WriteRegister1_IN = wr; RegWrite1_IN = 1'b1; Instr1_IN = instr;
    Instr1_PC_IN = 32'h00000400;
  endtask

  task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    set_mem(op, addr, 1'b1, 5'd9, 32'h8C090000);
    dreq_ready = 1'b1;
    #1;
    chk({tag, "_valid"}, {31'd0, dreq_valid}, 32'd1);
    chk({tag, "_addr"}, dreq_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"}, {28'd0, dreq_be}, 32'hF);
    chk({tag, "_write"}, {31'd0, dreq_write}, 32'd0);
    chk({tag, "_stall0"}, {31'd0, stall_MEM}, 32'd1);
    tick();
    chk({tag, "_bubble_rw"}, {31'd0, RegWrite1_OUT}, 32'd0);
    chk({tag, "_bubble_ins"}, Instr1_OUT, 32'd0);
    dreq_ready = 1'b0; dresp_valid = 1'b1; dresp_rdata = rdata;
    #1;
    chk({tag, "_stall1"}, {31'd0, stall_MEM}, 32'd0);
    tick();
    set_nop();
    chk({tag, "_data"}, WriteData1_OUT, exp);
    chk({tag, "_rw"}, {31'd0, RegWrite1_OUT}, 32'd1);
    chk({tag, "_wreg"}, {27'd0, WriteRegister1_OUT}, 32'd9);
  endtask

  initial begin
    set_nop();
    stall_IC = 1'b0;
    RESET = 1'b0;
    set_mem(6'h23, 32'h00003000, 1'b1, 5'd7, 32'h8C070000);
    #12;
    chk("rst_valid", {31'd0, dreq_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall_MEM}, 32'd0);
    chk("rst_wdata", WriteData1_OUT, 32'd0);
    chk("rst_rw", {31'd0, RegWrite1_OUT}, 32'd0);
    chk("rst_byp", {26'd0, BypassValid1_MEMEXE, BypassReg1_MEMEXE}, 32'd0);
    RESET = 1'b1;
    set_nop();

    // ADD pass-through
    Instr1_IN = 32'h00221820; Instr1_PC_IN = 32'h00000100; ALU_result1_IN = 32'h00000007;
    WriteRegister1_IN = 5'd3; RegWrite1_IN = 1'b1; ALU_Control1_IN = 6'h01;
    #1;
    chk("add_stall", {31'd0, stall_MEM}, 32'd0);
    chk("add_valid", {31'd0, dreq_valid}, 32'd0);
    tick();
    chk("add_data", WriteData1_OUT, 32'h7);
    chk("add_wreg", {27'd0, WriteRegister1_OUT}, 32'd3);
    chk("add_rw", {31'd0, RegWrite1_OUT}, 32'd1);
    chk("add_pc", Instr1_PC_OUT, 32'h100);
    chk("add_byp_d", BypassData1_MEMEXE, 32'h7);
    chk("add_byp_r", {27'd0, BypassReg1_MEMEXE}, 32'd3);
    chk("add_byp_v", {31'd0, BypassValid1_MEMEXE}, 32'd1);

    // stall_IC freezes the output registers
    ALU_result1_IN = 32'h00000055; WriteRegister1_IN = 5'd4; stall_IC = 1'b1;
    tick();
    chk("frz_data", WriteData1_OUT, 32'h7);
    chk("frz_wreg", {27'd0, WriteRegister1_OUT}, 32'd3);
    stall_IC = 1'b0;
    tick();
    chk("unfrz_data", WriteData1_OUT, 32'h55);
    chk("unfrz_byp", {27'd0, BypassReg1_MEMEXE}, 32'd4);
    set_nop();

    do_load("lb", 6'h20, 32'h00001003, 32'h112233F0, 32'hFFFFFFF0);
    do_load("lbu", 6'h24, 32'h00001003, 32'h112233F0, 32'h000000F0);
    do_load("lh", 6'h21, 32'h00001002, 32'h00008001, 32'hFFFF8001);
    do_load("lhu", 6'h25, 32'h00001000, 32'h8001FFFF, 32'h00008001);
    do_load("lb1", 6'h20, 32'h00001001, 32'h117F2233, 32'h0000007F);

    // SB lanes, observed before any edge
    set_mem(6'h28, 32'h00002001, 1'b0, 5'd0, 32'hA0000000);
    MemWriteData1_IN = 32'h12345678;
    #1;
    chk("sb_wdata", dreq_wdata, 32'h78787878);
    chk("sb_be", {28'd0, dreq_be}, 32'h4);
    set_nop();

    // SH store with ack
    set_mem(6'h29, 32'h00002002, 1'b0, 5'd5, 32'hA4000000);
    MemWriteData1_IN = 32'hAAAA5678; dreq_ready = 1'b1;
    #1;
    chk("sh_wdata", dreq_wdata, 32'h56785678);
    chk("sh_be", {28'd0, dreq_be}, 32'h3);
    chk("sh_write", {31'd0, dreq_write}, 32'd1);
    chk("sh_addr", dreq_addr, 32'h00002000);
    tick();
    dreq_ready = 1'b0; dresp_valid = 1'b1;
    tick();
    set_nop();
    chk("sh_rw", {31'd0, RegWrite1_OUT}, 32'd0);
    chk("sh_ins", Instr1_OUT, 32'hA4000000);

    // LW with slow ready and stall_IC during the response
    set_mem(6'h23, 32'h00003000, 1'b1, 5'd7, 32'h8C070000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_hold_valid", {31'd0, dreq_valid}, 32'd1);
      chk("lw_hold_addr", dreq_addr, 32'h00003000);
      chk("lw_hold_stall", {31'd0, stall_MEM}, 32'd1);
      tick();
      chk("lw_hold_bub", {31'd0, RegWrite1_OUT}, 32'd0);
    end
    dreq_ready = 1'b1;
    #1;
    chk("lw_acc_valid", {31'd0, dreq_valid}, 32'd1);
    tick();
    dreq_ready = 1'b1;
    #1;
    chk("lw_nodup", {31'd0, dreq_valid}, 32'd0);
    chk("lw_w1_stall", {31'd0, stall_MEM}, 32'd1);
    tick();
    dreq_ready = 1'b0; dresp_valid = 1'b1; dresp_rdata = 32'hCAFEBABE; stall_IC = 1'b1;
    #1;
    chk("lw_w2_stall", {31'd0, stall_MEM}, 32'd1);
    tick();
    dresp_valid = 1'b0; dresp_rdata = 32'hDEADBEEF; stall_IC = 1'b0;
    #1;
    chk("lw_hold_st", {31'd0, stall_MEM}, 32'd0);
    chk("lw_hold_nv", {31'd0, dreq_valid}, 32'd0);
    chk("lw_hold_rw", {31'd0, RegWrite1_OUT}, 32'd0);
    tick();
    set_nop();
    chk("lw_data", WriteData1_OUT, 32'hCAFEBABE);
    chk("lw_rw", {31'd0, RegWrite1_OUT}, 32'd1);
    chk("lw_wreg", {27'd0, WriteRegister1_OUT}, 32'd7);

    // misaligned LW
    set_mem(6'h23, 32'h00004002, 1'b1, 5'd8, 32'h8C080000);
    dreq_ready = 1'b1;
    #1;
    chk("mis_valid", {31'd0, dreq_valid}, 32'd0);
    chk("mis_stall", {31'd0, stall_MEM}, 32'd0);
    tick();
    set_nop();
    chk("mis_flag", {31'd0, Misalign_OUT}, 32'd1);
    chk("mis_rw", {31'd0, RegWrite1_OUT}, 32'd0);

    // reset while in WAIT, late response ignored
    set_mem(6'h23, 32'h00005000, 1'b1, 5'd6, 32'h8C060000);
    dreq_ready = 1'b1;
    #1;
    tick();
    dreq_ready = 1'b0;
    #1;
    RESET = 1'b0;
    #1;
    chk("rw_rst_data", WriteData1_OUT, 32'd0);
    chk("rw_rst_ins", Instr1_OUT, 32'd0);
    chk("rw_rst_valid", {31'd0, dreq_valid}, 32'd0);
    chk("rw_rst_stall", {31'd0, stall_MEM}, 32'd0);
    RESET = 1'b1;
    dresp_valid = 1'b1; dresp_rdata = 32'h12345678;
    #1;
    chk("rw_idle_valid", {31'd0, dreq_valid}, 32'd1);
    tick();
    chk("rw_ign_data", WriteData1_OUT, 32'd0);
    chk("rw_ign_rw", {31'd0, RegWrite1_OUT}, 32'd0);
    chk("rw_ign_byp", {31'd0, BypassValid1_MEMEXE}, 32'd0);
    set_nop();
    #1;
    chk("rw_end_valid", {31'd0, dreq_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have: CLK  in  1  clock, rising edge; reset RESET, asynchronous, active-low; clock CLK.
REQ-002 SHALL have: RESET  in  1  asynchronous, active-low reset.
REQ-003 SHALL have EXE-side inputs: Instr1_IN 32, Instr1_PC_IN 32, ALU_result1_IN 32 (effective address or result), WriteRegister1_IN 5, MemWriteData1_IN 32 (store data), RegWrite1_IN 1, ALU_Control1_IN 6, MemRead1_IN 1, MemWrite1_IN 1.
REQ-004 SHALL have: stall_IC  in  1  global pipeline freeze.
REQ-005 SHALL have: stall_MEM  out  1  holds EXE/earlier stages while a data access is outstanding.
REQ-006 SHALL have data-cache port:
- dreq_valid out 1
- dreq_ready in 1
- dreq_write out 1
- dreq_addr out 32, word-aligned
- dreq_wdata out 32
- dreq_be out 4, bit3 = byte 0
- dresp_valid in 1, read data or store acknowledge
- dresp_rdata in 32
REQ-007 SHALL have WB-side registered outputs: Instr1_OUT 32, Instr1_PC_OUT 32, WriteData1_OUT 32, WriteRegister1_OUT 5, RegWrite1_OUT 1, Misalign_OUT 1.
REQ-008 SHALL have forwarding outputs to EXE: BypassReg1_MEMEXE 5 = WriteRegister1_OUT, BypassData1_MEMEXE 32 = WriteData1_OUT, BypassValid1_MEMEXE 1 = RegWrite1_OUT.

Function
REQ-009 SHALL decode ALU_Control1_IN:
- loads: LB=0x20, LH=0x21, LW=0x23, LBU=0x24, LHU=0x25
- stores: SB=0x28, SH=0x29, SW=0x2B
- memop = (MemRead1_IN | MemWrite1_IN) with a code from this list
REQ-010 SHALL treat a non-memop as a one-cycle pass: when stall_IC=0, at the edge WriteData1_OUT<=ALU_result1_IN and all other fields are copied.
REQ-011 SHALL run an FSM with states IDLE, WAIT, HOLD.
REQ-012 IDLE, aligned memop: dreq_valid=1 combinationally; dreq_valid&dreq_ready at an edge -> WAIT. An unaccepted request SHALL remain stable.
REQ-013 WAIT: dresp_valid at an edge with stall_IC=0 -> IDLE and outputs written; with stall_IC=1 -> capture data into a buffer, go to HOLD.
REQ-014 HOLD: first edge with stall_IC=0 -> IDLE, outputs written from the buffer.
REQ-015 stall_MEM SHALL equal memop & !((WAIT&dresp_valid&!stall_IC) | (HOLD&!stall_IC)), and 0 for misaligned ops.
REQ-016 While stall_MEM=1 and stall_IC=0, each edge SHALL write a bubble: RegWrite1_OUT=0, Instr1_OUT=0, Misalign_OUT=0.
REQ-017 When stall_IC=1, all output registers SHALL hold.
REQ-018 Minimum load/store latency SHALL be 2 cycles: request accepted in cycle 0, response in cycle 1, outputs valid after the cycle-1 edge.
REQ-019 Addressing SHALL be big-endian, lane k = ALU_result1_IN[1:0], byte k = bits [31-8k:24-8k].
- dreq_addr = {addr[31:2],2'b00}
- dreq_write = MemWrite1_IN
REQ-020 Store lanes SHALL be:
- SB: wdata={4{rt[7:0]}}, be=4'b1000>>k
- SH: wdata={2{rt[15:0]}}, be=k[1]?0011:1100
- SW: wdata=rt, be=1111
REQ-021 Load results SHALL be:
- LB/LBU: sign-/zero-extended selected byte
- LH/LHU: sign-/zero-extended selected halfword
- LW: dresp_rdata
REQ-022 Stores SHALL complete with RegWrite1_OUT=0 regardless of RegWrite1_IN.
REQ-023 Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL:
- issue no request
- pass in one cycle with RegWrite1_OUT=0 and Misalign_OUT=1
REQ-024 dresp_valid in IDLE or HOLD SHALL be ignored.
REQ-025 dreq_ready SHALL be ignored unless dreq_valid=1.

Reset
REQ-026 RESET low SHALL immediately force:
- FSM=IDLE, buffer cleared
- dreq_valid=0, stall_MEM=0
- all WB outputs and bypass outputs 0
REQ-027 RESET asserted mid-transaction SHALL abandon it; a response arriving after release SHALL be ignored per REQ-024.

Verification
REQ-028 ADD result 0x00000007 to r3 -> after one edge: WriteData1_OUT=0x7, WriteRegister1_OUT=3, RegWrite1_OUT=1, Bypass mirrors; stall_MEM never 1.
REQ-029 LB addr 0x1003, dreq_ready=1, dresp next cycle rdata=0x112233F0 -> dreq_addr=0x1000, be=1111/write=0, stall_MEM high 1 cycle (bubble), WriteData1_OUT=0xFFFFFFF0; LBU -> 0x000000F0.
REQ-030 SH addr 0x2002, rt=0xAAAA5678 -> dreq_wdata=0x56785678, be=0011, write=1; RegWrite1_OUT=0 after ack.
REQ-031 LW addr 0x3000, dreq_ready low 3 cycles, dresp 2 cycles after accept with stall_IC=1 that cycle, low next -> request held stable 3 cycles, HOLD entered, result 0x... written on stall_IC release edge, no duplicate request.
REQ-032 LW addr 0x4002 -> no dreq_valid, Misalign_OUT=1, RegWrite1_OUT=0 after one edge.
REQ-033 RESET low while in WAIT, then dresp_valid=1 after release -> outputs 0, state IDLE, response ignored, no register write.
